multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be none; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction[31:26] from the external instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes and mux selects.
REQ-008 alu_src_b  output  2  ALU B mux: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-009 alu_op  output  2  to the ALU control decoder: 00 add, 01 subtract, 10 decode funct.
REQ-010 pc_src  output  2  PC mux: 00 ALU result, 01 ALU-out register, 10 jump target.
REQ-011 instr_done  output  1  one-cycle pulse on the last cycle of every instruction.
REQ-012 illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.
REQ-013 state  output  4  current state encoding, for debug.

Function
REQ-014 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-015 Supported opcodes SHALL be: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-016 Transitions SHALL be:
- FETCH->DECODE when mem_ready=1, else stay.
- DECODE->MEMADR for lw/sw, EXEC for R, BRANCH for beq, ADDIEX for addi, JUMP for j, FETCH for any other opcode.
- MEMADR->MEMRD for lw, MEMWR for sw.
- MEMRD->MEMWB when mem_ready=1, else stay.
- MEMWR->FETCH when mem_ready=1, else stay.
- EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP ->FETCH.
- Encodings 12-15 ->FETCH.
REQ-017 Outputs SHALL be combinational from state (plus mem_ready, zero and opcode where stated), and every output not listed for a state below SHALL be 0.
REQ-018 FETCH SHALL drive mem_read=1, alu_src_b=01, alu_op=00, pc_src=00, and ir_write=pc_en=mem_ready.
REQ-019 DECODE SHALL drive alu_src_b=11 and alu_op=00 (precompute the branch target).
REQ-020 MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-021 MEMRD SHALL drive iord=1, mem_read=1; MEMWR SHALL drive iord=1, mem_write=1; both SHALL hold steady while mem_ready=0.
REQ-022 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0; ALUWB SHALL drive reg_write=1, reg_dst=1; ADDIWB SHALL drive reg_write=1, reg_dst=0.
REQ-023 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-024 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero.
REQ-025 JUMP SHALL drive pc_src=10, pc_en=1.
REQ-026 instr_done SHALL be 1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, in the MEMWR cycle with mem_ready=1, and in DECODE when the opcode is illegal.
REQ-027 Latency with mem_ready held at 1 SHALL be: R 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles; each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-028 mem_read and mem_write SHALL never both be 1 in the same cycle.
REQ-029 pc_en SHALL be 1 in at most one cycle of FETCH per instruction.
REQ-030 opcode SHALL be sampled only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.

Reset
REQ-031 While rst_n=0, state SHALL be FETCH (0) and every output except state SHALL be forced to 0, regardless of clk.
REQ-032 Reset assertion mid-instruction SHALL abort the instruction immediately with no further strobes; the first cycle after release SHALL be FETCH.
REQ-033 Reset release SHALL take effect on the first rising clk edge after rst_n goes to 1; no output glitches above 0 while rst_n=0.

Verification
REQ-034 R-type, mem_ready=1 -> states 0,1,6,7; alu_op=10 in EXEC; reg_write=1, reg_dst=1 in ALUWB; instr_done pulses in cycle 4.
REQ-035 lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4 (7 cycles); iord=1, mem_read=1 throughout MEMRD; mem_to_reg=1 in MEMWB.
REQ-036 beq with zero=1, then beq with zero=0 -> pc_en=1, pc_src=01 in the first BRANCH cycle; pc_en=0 in the second; each instruction takes 3 cycles.
REQ-037 opcode=111111 -> DECODE pulses illegal_op=1 and instr_done=1, next state FETCH, reg_write and mem_write never 1.
REQ-038 rst_n driven low asynchronously in MEMWR (mid-cycle) -> all outputs 0 at once, state=0; after release, FETCH with mem_read=1 and no mem_write.
REQ-039 sw, then j, back-to-back -> mem_write=1 only in MEMWR; JUMP drives pc_src=10, pc_en=1; total 4+3 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes and mux selects from the current state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      // Anything other than sw is treated as a load so the access always completes.
      MEMADR: state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
      EXEC:   state_next = ALUWB;
      ADDIEX: state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  logic legal_op;
  always_comb begin
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal_op = 1'b1;
      default:                                   legal_op = 1'b0;
    endcase
  end

  // Control word order: pc_en ir_write iord mem_read mem_write reg_write reg_dst
  // mem_to_reg alu_src_a alu_src_b[1:0] alu_op[1:0] pc_src[1:0] instr_done illegal_op
  logic [16:0] ctl_next;

  always_comb begin
    ctl_next = '0;
    case (state_reg)
      FETCH:  ctl_next = {mem_ready, mem_ready, 1'b0, 1'b1, 5'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      DECODE: ctl_next = {9'b0, 2'b11, 2'b00, 2'b00, ~legal_op, ~legal_op};
      MEMADR, ADDIEX:
              ctl_next = {8'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
      MEMRD:  ctl_next = {2'b00, 1'b1, 1'b1, 5'b0, 8'b0};
      MEMWR:  ctl_next = {2'b00, 1'b1, 1'b0, 1'b1, 4'b0, 6'b0, mem_ready, 1'b0};
      MEMWB:  ctl_next = {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 2'b10};
      EXEC:   ctl_next = {8'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00};
      ALUWB:  ctl_next = {5'b0, 1'b1, 1'b1, 2'b00, 6'b0, 2'b10};
      ADDIWB: ctl_next = {5'b0, 1'b1, 3'b000, 6'b0, 2'b10};
      BRANCH: ctl_next = {zero, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b10};
      JUMP:   ctl_next = {1'b1, 8'b0, 2'b00, 2'b00, 2'b10, 2'b10};
      default: ctl_next = '0;
    endcase
  end

  // Gating with rst_n keeps every strobe low for as long as reset is held.
  assign {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
          alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op}
         = rst_n ? ctl_next : 17'b0;

  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues hand-computed expected
// state/control words per cycle; the monitor pops and compares them as they appear.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  // pc_en ir_wr iord mrd mwr rwr rdst m2r asa | srcb aluop pcsrc | done illegal
  localparam logic [16:0] C_RST   = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] C_F1    = 17'b1_1_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] C_F0    = 17'b0_0_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] C_DECX  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [16:0] C_ADR   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] C_MRD   = 17'b0_0_1_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] C_MWR0  = 17'b0_0_1_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] C_MWR1  = 17'b0_0_1_0_1_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [16:0] C_EXEC  = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] C_ALUWB = 17'b0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [16:0] C_ADDWB = 17'b0_0_0_0_0_1_0_0_0_00_00_00_1_0;
  localparam logic [16:0] C_BR1   = 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] C_BR0   = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  event sample_ev;

  task automatic step(input logic rst, input logic [5:0] opc, input logic z, input logic mr,
                      input logic [3:0] st, input logic [16:0] ctl, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; opcode = opc; zero = z; mem_ready = mr;
    e.name = name; e.st = st; e.ctl = ctl;
    q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [16:0] act;
    e = q.pop_front();
    act = {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};
    n_vec++;
    if (act !== e.ctl || state !== e.st) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctl=%b, required state=%0d ctl=%b",
               e.name, state, act, e.st, e.ctl);
    end else
      $display("vec %0d %s state=%0d ctl=%b ok", n_vec, e.name, state, act);
  endtask

  initial begin
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) check_now();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = R; zero = 1'b0; mem_ready = 1'b1;
    step(0, R, 0, 1, 0, C_RST, "reset0");
    step(0, R, 0, 1, 0, C_RST, "reset1");
    // R-type; opcode disturbed after DECODE must not matter
    step(1, R,   0, 1, 0, C_F1,    "R.fetch");
    step(1, R,   0, 1, 1, C_DEC,   "R.decode");
    step(1, BAD, 0, 1, 6, C_EXEC,  "R.exec");
    step(1, SW,  0, 1, 7, C_ALUWB, "R.aluwb");
    // lw with a stalled fetch and two stalled reads
    step(1, LW, 0, 0, 0, C_F0,  "lw.fetch_wait");
    step(1, LW, 0, 1, 0, C_F1,  "lw.fetch");
    step(1, LW, 0, 1, 1, C_DEC, "lw.decode");
    step(1, LW, 0, 1, 2, C_ADR, "lw.memadr");
    step(1, LW, 0, 0, 3, C_MRD, "lw.memrd_w0");
    step(1, LW, 0, 0, 3, C_MRD, "lw.memrd_w1");
    step(1, LW, 0, 1, 3, C_MRD, "lw.memrd");
    step(1, LW, 0, 1, 4, C_MWB, "lw.memwb");
    // beq taken then not taken
    step(1, BEQ, 1, 1, 0, C_F1,  "beq1.fetch");
    step(1, BEQ, 1, 1, 1, C_DEC, "beq1.decode");
    step(1, BEQ, 1, 1, 8, C_BR1, "beq1.branch");
    step(1, BEQ, 0, 1, 0, C_F1,  "beq0.fetch");
    step(1, BEQ, 0, 1, 1, C_DEC, "beq0.decode");
    step(1, BEQ, 0, 1, 8, C_BR0, "beq0.branch");
    // addi
    step(1, ADDI, 0, 1, 0,  C_F1,    "addi.fetch");
    step(1, ADDI, 0, 1, 1,  C_DEC,   "addi.decode");
    step(1, ADDI, 0, 1, 9,  C_ADR,   "addi.ex");
    step(1, ADDI, 0, 1, 10, C_ADDWB, "addi.wb");
    // illegal opcode aborts from DECODE
    step(1, BAD, 0, 1, 0, C_F1,   "bad.fetch");
    step(1, BAD, 0, 1, 1, C_DECX, "bad.decode");
    // sw then j back-to-back
    step(1, SW, 0, 1, 0,  C_F1,   "sw.fetch");
    step(1, SW, 0, 1, 1,  C_DEC,  "sw.decode");
    step(1, SW, 0, 1, 2,  C_ADR,  "sw.memadr");
    step(1, SW, 0, 1, 5,  C_MWR1, "sw.memwr");
    step(1, J,  0, 1, 0,  C_F1,   "j.fetch");
    step(1, J,  0, 1, 1,  C_DEC,  "j.decode");
    step(1, J,  0, 1, 11, C_JMP,  "j.jump");
    // sw stalled in MEMWR, then asynchronous reset mid-cycle
    step(1, SW, 0, 1, 0, C_F1,   "swr.fetch");
    step(1, SW, 0, 1, 1, C_DEC,  "swr.decode");
    step(1, SW, 0, 1, 2, C_ADR,  "swr.memadr");
    step(1, SW, 0, 0, 5, C_MWR0, "swr.memwr_wait");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    begin
      exp_t e;
      e.name = "async_reset"; e.st = 4'd0; e.ctl = C_RST;
      q.push_back(e);
    end
    ->sample_ev;
    step(0, SW, 1, 1, 0, C_RST, "reset_hold0");
    step(0, SW, 1, 1, 0, C_RST, "reset_hold1");
    step(1, SW, 0, 1, 0, C_F1,  "post.fetch");
    step(1, SW, 0, 1, 1, C_DEC, "post.decode");
    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
